mdu_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit with its own sequencing FSM, sitting beside the ALU in the Execute stage of the 5-stage pipeline.
- Accepts one M-extension op per start, holds the pipeline via a stall line to the hazard unit while iterating, and presents a one-cycle-valid result that the E-stage result mux selects in place of the ALU output.
- Shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/mdu_sequencer_pkg.sv | 25 ++
 rtl/mdu_datapath.sv | 130 +++++++++++++
 rtl/mdu_sequencer.sv | 105 ++++++++++
 tb/tb_mdu_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mdu_sequencer_pkg.sv
// rtl/mdu_sequencer_pkg.sv - shared constants, M-ext funct3 encodings and sequencer states
package mdu_sequencer_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// rtl/mdu_datapath.sv - magnitude shift-add multiply / restoring divide datapath with sign correction
module mdu_datapath
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN = mdu_sequencer_pkg::XLEN
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic            i_mul_step,
    input  logic            i_div_step,
    input  logic            i_done,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_src_a,
    input  logic [XLEN-1:0] i_src_b,
    output logic            o_special,
    output logic [XLEN-1:0] o_result
);

    logic [2:0]        r_op;
    logic              r_sign_a;
    logic              r_sign_b;
    logic [XLEN-1:0]   r_mag_a;
    logic [XLEN-1:0]   r_mag_b;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic              r_special;
    logic [XLEN-1:0]   r_special_res;
    logic [XLEN-1:0]   r_result;

    logic              w_signed_a;
    logic              w_signed_b;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div_zero;
    logic              w_overflow;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_shift;
    logic              w_rem_ge;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    // MUL is computed on signed magnitudes; its low half is sign-agnostic anyway
    always_comb begin
        w_signed_a = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU)
                  || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
        w_signed_b = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH)
                  || (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
        w_sign_a   = w_signed_a && i_src_a[XLEN-1];
        w_sign_b   = w_signed_b && i_src_b[XLEN-1];
        w_mag_a    = w_sign_a ? -i_src_a : i_src_a;
        w_mag_b    = w_sign_b ? -i_src_b : i_src_b;

        w_div_zero = i_funct3[2] && (i_src_b == '0);
        w_overflow = i_funct3[2] && !i_funct3[0]
                  && (i_src_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_src_b == '1);
        o_special  = w_div_zero || w_overflow;

        if (w_div_zero) begin
            w_special_res = i_funct3[1] ? i_src_a : '1;
        end else begin
            w_special_res = i_funct3[1] ? '0 : i_src_a;
        end
    end

    always_comb begin
        w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
        w_rem_shift = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
        w_rem_ge    = (w_rem_shift >= {1'b0, r_mag_b});
    end

    // unsigned ops latch both signs as 0, so one XOR covers MUL/MULH/MULHSU/MULHU
    always_comb begin
        w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
        w_quo  = (r_sign_a ^ r_sign_b) ? -r_quo : r_quo;
        w_rem  = r_sign_a ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
        if (r_special) begin
            w_final = r_special_res;
        end else if (!r_op[2]) begin
            w_final = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else begin
            w_final = r_op[1] ? w_rem : w_quo;
        end
        o_result = i_done ? w_final : r_result;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op          <= '0;
            r_sign_a      <= 1'b0;
            r_sign_b      <= 1'b0;
            r_mag_a       <= '0;
            r_mag_b       <= '0;
            r_acc         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_special     <= 1'b0;
            r_special_res <= '0;
            r_result      <= '0;
        end else begin
            if (i_load) begin
                r_op          <= i_funct3;
                r_sign_a      <= w_sign_a;
                r_sign_b      <= w_sign_b;
                r_mag_a       <= w_mag_a;
                r_mag_b       <= w_mag_b;
                r_acc         <= {{XLEN{1'b0}}, w_mag_b};
                r_rem         <= '0;
                r_quo         <= w_mag_a;
                r_special     <= o_special;
                r_special_res <= w_special_res;
            end else if (i_mul_step) begin
                r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
            end else if (i_div_step) begin
                r_rem <= w_rem_ge ? (w_rem_shift - {1'b0, r_mag_b}) : w_rem_shift;
                r_quo <= {r_quo[XLEN-2:0], w_rem_ge};
            end
            if (i_done) begin
                r_result <= w_final;
            end
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - RV32M iterative multiply/divide sequencer FSM with pipeline stall
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN  = mdu_sequencer_pkg::XLEN,
    parameter int CNT_W = mdu_sequencer_pkg::CNT_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            MDUStartE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            KillE,
    output logic            StallMDU,
    output logic [XLEN-1:0] MDUResultE,
    output logic            MDUValidE,
    output logic            MDUBusy
);

    mdu_state_e       r_state;
    mdu_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_special;
    logic             w_last;
    logic             w_mul_step;
    logic             w_div_step;
    logic             w_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // kill wins over start and over every in-flight state
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_last      = (r_cnt == CNT_W'(XLEN-1));
        w_mul_step  = 1'b0;
        w_div_step  = 1'b0;
        w_done      = 1'b0;
        StallMDU    = 1'b0;
        MDUValidE   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_accept = MDUStartE && !KillE;
                StallMDU = w_accept;
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    if (w_special) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = funct3E[2] ? ST_DIV : ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                StallMDU   = 1'b1;
                w_mul_step = (r_state == ST_MUL) && !KillE;
                w_div_step = (r_state == ST_DIV) && !KillE;
                if (KillE) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_done      = !KillE;
                MDUValidE   = !KillE;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        MDUBusy = (r_state != ST_IDLE);
    end

    mdu_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_load     (w_accept),
        .i_mul_step (w_mul_step),
        .i_div_step (w_div_step),
        .i_done     (w_done),
        .i_funct3   (funct3E),
        .i_src_a    (SrcAE),
        .i_src_b    (SrcBE),
        .o_special  (w_special),
        .o_result   (MDUResultE)
    );

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;

    logic        clock;
    logic        reset;
    logic        MDUStartE;
    logic [2:0]  funct3E;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        KillE;
    logic        StallMDU;
    logic [31:0] MDUResultE;
    logic        MDUValidE;
    logic        MDUBusy;

    int n_vec = 0;
    int n_bad = 0;

    mdu_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .MDUStartE  (MDUStartE),
        .funct3E    (funct3E),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .KillE      (KillE),
        .StallMDU   (StallMDU),
        .MDUResultE (MDUResultE),
        .MDUValidE  (MDUValidE),
        .MDUBusy    (MDUBusy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
        int          stalls = 0;
        bit          got    = 1'b0;
        logic [31:0] res    = '0;
        @(negedge clock);
        MDUStartE = 1'b1;
        funct3E   = f3;
        SrcAE     = a;
        SrcBE     = b;
        for (int c = 0; c < 64 && !got; c++) begin
            #1;
            if (StallMDU) stalls++;
            if (MDUValidE) begin
                got = 1'b1;
                res = MDUResultE;
            end
            @(negedge clock);
            MDUStartE = 1'b0;
        end
        #1;
        check({tag, ".valid"},  {31'b0, got}, 32'd1);
        check({tag, ".stall"},  32'(stalls), 32'(exp_stall));
        check({tag, ".result"}, res, exp);
        check({tag, ".onecyc"}, {31'b0, MDUValidE}, 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        MDUStartE = 1'b0;
        funct3E   = 3'b000;
        SrcAE     = '0;
        SrcBE     = '0;
        KillE     = 1'b0;
        #22;
        check("rst.stall",  {31'b0, StallMDU},  32'd0);
        check("rst.valid",  {31'b0, MDUValidE}, 32'd0);
        check("rst.busy",   {31'b0, MDUBusy},   32'd0);
        check("rst.result", MDUResultE,         32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("mul_7_m3",  3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu_ff",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulh_ff",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_op("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div_m7_2",  3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",  3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33);
        run_op("divu_100_7",3'b101, 32'd100,       32'd7,         32'd14,        33);
        run_op("remu_100_7",3'b111, 32'd100,       32'd7,         32'd2,         33);
        run_op("divu_5_0",  3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_5_0",   3'b110, 32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // kill a DIV during iteration 10
        @(negedge clock);
        MDUStartE = 1'b1;
        funct3E   = 3'b100;
        SrcAE     = 32'd1000;
        SrcBE     = 32'd3;
        @(negedge clock);
        MDUStartE = 1'b0;
        repeat (10) @(negedge clock);
        KillE = 1'b1;
        #1;
        check("kill.busy_before", {31'b0, MDUBusy}, 32'd1);
        @(negedge clock);
        KillE = 1'b0;
        #1;
        check("kill.stall", {31'b0, StallMDU},  32'd0);
        check("kill.busy",  {31'b0, MDUBusy},   32'd0);
        check("kill.valid", {31'b0, MDUValidE}, 32'd0);
        run_op("mul_after_kill", 3'b000, 32'd3, 32'd4, 32'd12, 33);

        // asynchronous reset during iteration 20 of a MUL
        @(negedge clock);
        MDUStartE = 1'b1;
        funct3E   = 3'b000;
        SrcAE     = 32'd5;
        SrcBE     = 32'd6;
        @(negedge clock);
        MDUStartE = 1'b0;
        repeat (20) @(negedge clock);
        #1;
        check("areset.busy_before", {31'b0, MDUBusy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("areset.stall",  {31'b0, StallMDU},  32'd0);
        check("areset.busy",   {31'b0, MDUBusy},   32'd0);
        check("areset.valid",  {31'b0, MDUValidE}, 32'd0);
        check("areset.result", MDUResultE,         32'd0);
        @(negedge clock);
        reset = 1'b1;
        run_op("mul_after_rst", 3'b000, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
